stream_demux_2: RTL and testbench

Registered 1-to-2 stream demultiplexer: the write-side counterpart of `mux_2`. It accepts one XLEN-wide valid/ready input stream carrying a per-beat select bit and steers each beat to one of two valid/ready output streams. Each output has a private 2-entry buffer, so a stalled consumer blocks only beats destined for it. It sits between the issue stage and the two accelerator datapaths (lane 0 / lane 1), where results and operands are fanned out.

---
 rtl/stream_demux_2.sv | 101 ++++++++++
 tb/tb_stream_demux_2.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_2.sv
// Registered 1-to-2 valid/ready stream demultiplexer.
// Each output owns a private 2-entry FIFO; in_ready depends only on in_sel and counts.
package riscv_pkg;
   localparam int XLEN = 32;
endpackage

module stream_demux_2
   import riscv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out_0_valid,
   input  logic             out_0_ready,
   output logic [WIDTH-1:0] out_0_data,
   output logic             out_1_valid,
   input  logic             out_1_ready,
   output logic [WIDTH-1:0] out_1_data
);

   logic [WIDTH-1:0] mem0_q [2];
   logic [WIDTH-1:0] mem1_q [2];
   logic             wp0_q, wp0_d, rp0_q, rp0_d;
   logic             wp1_q, wp1_d, rp1_q, rp1_d;
   logic [1:0]       cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic             push0, push1, pop0, pop1;

   // Full means full: a same-cycle pop never frees room for a push.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         in_ready = in_sel ? (cnt1_q != 2'd2) : (cnt0_q != 2'd2);
      end
   end

   assign push0 = in_valid && in_ready && !in_sel;
   assign push1 = in_valid && in_ready && in_sel;
   assign pop0  = out_0_valid && out_0_ready;
   assign pop1  = out_1_valid && out_1_ready;

   assign out_0_valid = (cnt0_q != 2'd0);
   assign out_1_valid = (cnt1_q != 2'd0);
   assign out_0_data  = mem0_q[rp0_q];
   assign out_1_data  = mem1_q[rp1_q];

   always_comb begin
      wp0_d  = wp0_q;
      rp0_d  = rp0_q;
      cnt0_d = cnt0_q;
      if (push0) wp0_d = ~wp0_q;
      if (pop0)  rp0_d = ~rp0_q;
      unique case ({push0, pop0})
         2'b10:   cnt0_d = cnt0_q + 2'd1;
         2'b01:   cnt0_d = cnt0_q - 2'd1;
         default: cnt0_d = cnt0_q;
      endcase
   end

   always_comb begin
      wp1_d  = wp1_q;
      rp1_d  = rp1_q;
      cnt1_d = cnt1_q;
      if (push1) wp1_d = ~wp1_q;
      if (pop1)  rp1_d = ~rp1_q;
      unique case ({push1, pop1})
         2'b10:   cnt1_d = cnt1_q + 2'd1;
         2'b01:   cnt1_d = cnt1_q - 2'd1;
         default: cnt1_d = cnt1_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp0_q     <= 1'b0;
         rp0_q     <= 1'b0;
         cnt0_q    <= 2'd0;
         wp1_q     <= 1'b0;
         rp1_q     <= 1'b0;
         cnt1_q    <= 2'd0;
         mem0_q[0] <= '0;
         mem0_q[1] <= '0;
         mem1_q[0] <= '0;
         mem1_q[1] <= '0;
      end else begin
         wp0_q  <= wp0_d;
         rp0_q  <= rp0_d;
         cnt0_q <= cnt0_d;
         wp1_q  <= wp1_d;
         rp1_q  <= rp1_d;
         cnt1_q <= cnt1_d;
         if (push0) mem0_q[wp0_q] <= in_data;
         if (push1) mem1_q[wp1_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_stream_demux_2.sv
// Directed self-checking bench for stream_demux_2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stream_demux_2;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_sel;
   logic        out_0_valid;
   logic        out_0_ready;
   logic [31:0] out_0_data;
   logic        out_1_valid;
   logic        out_1_ready;
   logic [31:0] out_1_data;

   int total = 0;
   int bad   = 0;

   stream_demux_2 #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .out_0_valid (out_0_valid),
      .out_0_ready (out_0_ready),
      .out_0_data  (out_0_data),
      .out_1_valid (out_1_valid),
      .out_1_ready (out_1_ready),
      .out_1_data  (out_1_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD;
      out_0_ready = 1'b1; out_1_ready = 1'b1;
      cyc(); cyc();
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL rst_in_ready got %b want 0", in_ready);
      end
      total++;
      if ({out_0_valid, out_1_valid} !== 2'b00) begin
         bad++; $display("FAIL rst_valids got %b want 00", {out_0_valid, out_1_valid});
      end
      total++;
      if (out_0_data !== 32'h0 || out_1_data !== 32'h0) begin
         bad++; $display("FAIL rst_data got %h %h want 0 0", out_0_data, out_1_data);
      end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL idle_ready_sel0 got %b want 1", in_ready);
      end
      in_sel = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL idle_ready_sel1 got %b want 1", in_ready);
      end
      total++;
      if ({out_0_valid, out_1_valid} !== 2'b00) begin
         bad++; $display("FAIL idle_valids got %b want 00", {out_0_valid, out_1_valid});
      end
      cyc();
   endtask

   task automatic test_basic();
      out_0_ready = 1'b1; out_1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0000_1100;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL basic_ready got %b want 1", in_ready);
      end
      cyc();
      in_sel = 1'b1; in_data = 32'h0000_0011;
      #1;
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'h1100) begin
         bad++; $display("FAIL basic_out0 got %b/%h want 1/00001100", out_0_valid, out_0_data);
      end
      total++;
      if (out_1_valid !== 1'b0) begin
         bad++; $display("FAIL basic_out1_early got %b want 0", out_1_valid);
      end
      cyc();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_0_valid !== 1'b0) begin
         bad++; $display("FAIL basic_out0_once got %b want 0", out_0_valid);
      end
      total++;
      if (out_1_valid !== 1'b1 || out_1_data !== 32'h0011) begin
         bad++; $display("FAIL basic_out1 got %b/%h want 1/00000011", out_1_valid, out_1_data);
      end
      cyc();
      total++;
      if (out_1_valid !== 1'b0) begin
         bad++; $display("FAIL basic_out1_once got %b want 0", out_1_valid);
      end
   endtask

   task automatic test_full();
      out_0_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0;
      in_data = 32'hA; cyc();
      in_data = 32'hB; cyc();
      in_data = 32'hC;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL full_ready got %b want 0", in_ready);
      end
      cyc();
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'hA) begin
         bad++; $display("FAIL full_headA got %b/%h want 1/0000000a", out_0_valid, out_0_data);
      end
      out_0_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL full_pop_cycle_ready got %b want 0", in_ready);
      end
      cyc();
      total++;
      if (out_0_data !== 32'hB || in_ready !== 1'b1) begin
         bad++; $display("FAIL full_headB got %h/%b want 0000000b/1", out_0_data, in_ready);
      end
      cyc();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'hC) begin
         bad++; $display("FAIL full_headC got %b/%h want 1/0000000c", out_0_valid, out_0_data);
      end
      cyc();
      total++;
      if (out_0_valid !== 1'b0) begin
         bad++; $display("FAIL full_drained got %b want 0", out_0_valid);
      end
   endtask

   task automatic test_indep();
      out_0_ready = 1'b0; out_1_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0;
      in_data = 32'hE0; cyc();
      in_data = 32'hE1; cyc();
      in_sel = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'(i + 1);
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++; $display("FAIL indep_ready[%0d] got %b want 1", i, in_ready);
         end
         if (i > 0) begin
            total++;
            if (out_1_valid !== 1'b1 || out_1_data !== 32'(i)) begin
               bad++;
               $display("FAIL indep_out1[%0d] got %b/%h want 1/%h", i, out_1_valid, out_1_data, 32'(i));
            end
         end
         cyc();
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (out_1_valid !== 1'b1 || out_1_data !== 32'h4) begin
         bad++; $display("FAIL indep_out1_last got %b/%h want 1/00000004", out_1_valid, out_1_data);
      end
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'hE0) begin
         bad++; $display("FAIL indep_out0_hold got %b/%h want 1/000000e0", out_0_valid, out_0_data);
      end
      in_sel = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL indep_out0_full got %b want 0", in_ready);
      end
      out_0_ready = 1'b1;
      cyc();
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'hE1 || out_1_valid !== 1'b0) begin
         bad++;
         $display("FAIL indep_drain got %b/%h/%b want 1/000000e1/0", out_0_valid, out_0_data, out_1_valid);
      end
      cyc();
      total++;
      if (out_0_valid !== 1'b0) begin
         bad++; $display("FAIL indep_empty got %b want 0", out_0_valid);
      end
   endtask

   task automatic test_stream();
      out_0_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h10 + 32'(i);
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready);
         end
         if (i > 0) begin
            total++;
            if (out_0_valid !== 1'b1 || out_0_data !== 32'h10 + 32'(i - 1)) begin
               bad++;
               $display("FAIL stream_out[%0d] got %b/%h want 1/%h", i, out_0_valid, out_0_data, 32'h10 + 32'(i - 1));
            end
         end
         cyc();
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (out_0_valid !== 1'b1 || out_0_data !== 32'h17) begin
         bad++; $display("FAIL stream_last got %b/%h want 1/00000017", out_0_valid, out_0_data);
      end
      cyc();
      total++;
      if (out_0_valid !== 1'b0) begin
         bad++; $display("FAIL stream_empty got %b want 0", out_0_valid);
      end
   endtask

   task automatic test_mid_reset();
      out_1_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1;
      in_data = 32'h21; cyc();
      in_data = 32'h22; cyc();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_1_valid !== 1'b1 || out_1_data !== 32'h21) begin
         bad++; $display("FAIL mrst_pre got %b/%h want 1/00000021", out_1_valid, out_1_data);
      end
      rst = 1'b1; in_valid = 1'b1; in_data = 32'h99;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL mrst_ready_in_rst got %b want 0", in_ready);
      end
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      total++;
      if (out_1_valid !== 1'b0 || out_0_valid !== 1'b0 || out_1_data !== 32'h0) begin
         bad++;
         $display("FAIL mrst_cleared got %b/%b/%h want 0/0/0", out_1_valid, out_0_valid, out_1_data);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL mrst_ready_after got %b want 1", in_ready);
      end
      out_1_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h55;
      cyc();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_1_valid !== 1'b1 || out_1_data !== 32'h55 || out_0_valid !== 1'b0) begin
         bad++;
         $display("FAIL mrst_new got %b/%h/%b want 1/00000055/0", out_1_valid, out_1_data, out_0_valid);
      end
      cyc();
      total++;
      if (out_1_valid !== 1'b0) begin
         bad++; $display("FAIL mrst_new_once got %b want 0", out_1_valid);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out_0_ready = 1'b0; out_1_ready = 1'b0;
      test_reset();
      test_basic();
      test_full();
      test_indep();
      test_stream();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
